// File: rtl/riscv_inst_pkg.sv
// Shared encodings for the load/store stage: one-hot instruction constants,
// FSM states, byte strobes, the decoded memory-op payload and decode helpers.
package riscv_inst_pkg;

    localparam logic [63:0] inst_lb  = 64'd1 << 10;
    localparam logic [63:0] inst_lh  = 64'd1 << 11;
    localparam logic [63:0] inst_lw  = 64'd1 << 12;
    localparam logic [63:0] inst_lbu = 64'd1 << 13;
    localparam logic [63:0] inst_lhu = 64'd1 << 14;
    localparam logic [63:0] inst_sb  = 64'd1 << 15;
    localparam logic [63:0] inst_sh  = 64'd1 << 16;
    localparam logic [63:0] inst_sw  = 64'd1 << 17;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_e;

    localparam logic [3:0] WE_NONE = 4'b0000;
    localparam logic [3:0] WE_BYTE = 4'b0001;
    localparam logic [3:0] WE_HLO  = 4'b0011;
    localparam logic [3:0] WE_HHI  = 4'b1100;
    localparam logic [3:0] WE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } mem_size_e;

    typedef struct packed {
        logic      is_load;
        logic      is_store;
        mem_size_e size;
        logic      is_unsigned;
    } mem_op_t;

    typedef struct packed {
        mem_op_t    op;
        logic [1:0] offset;
        logic [4:0] rd;
    } lsu_req_t;

    function automatic mem_op_t decode_op(input logic [63:0] inst);
        mem_op_t op;
        op = '{is_load: 1'b0, is_store: 1'b0, size: SZ_W, is_unsigned: 1'b0};
        case (inst)
            inst_lb:  op = '{1'b1, 1'b0, SZ_B, 1'b0};
            inst_lh:  op = '{1'b1, 1'b0, SZ_H, 1'b0};
            inst_lw:  op = '{1'b1, 1'b0, SZ_W, 1'b0};
            inst_lbu: op = '{1'b1, 1'b0, SZ_B, 1'b1};
            inst_lhu: op = '{1'b1, 1'b0, SZ_H, 1'b1};
            inst_sb:  op = '{1'b0, 1'b1, SZ_B, 1'b0};
            inst_sh:  op = '{1'b0, 1'b1, SZ_H, 1'b0};
            inst_sw:  op = '{1'b0, 1'b1, SZ_W, 1'b0};
            default:  ;
        endcase
        return op;
    endfunction

    function automatic logic misaligned(input mem_op_t op, input logic [1:0] lo);
        return (op.is_load || op.is_store) &&
               (((op.size == SZ_H) && lo[0]) || ((op.size == SZ_W) && (lo != 2'b00)));
    endfunction

    function automatic logic [31:0] align_addr(input mem_op_t op, input logic [31:0] a);
        logic [31:0] r;
        r = a;
        if (op.size == SZ_H) r[0] = 1'b0;
        if (op.size == SZ_W) r[1:0] = 2'b00;
        return r;
    endfunction

    function automatic logic [3:0] store_strobe(input mem_size_e size, input logic [1:0] lo);
        case (size)
            SZ_B:    return WE_BYTE << lo;
            SZ_H:    return lo[1] ? WE_HHI : WE_HLO;
            default: return WE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module lsu_load_align
    import riscv_inst_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  mem_size_e   size,
    input  logic        is_unsigned,
    output logic [31:0] value_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    value_c = is_unsigned ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_H:    value_c = is_unsigned ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: value_c = word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store stage between execute and word-addressed data memory.
// Build option LSU_MISALIGN_TRAP_EN: trap misaligned ops instead of force-aligning them.
module lsu_mem_stage
    import riscv_inst_pkg::*;
#(
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned MEM_WORDS = 131072
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] Single_Instruction,
    input  logic [31:0] rs1_val,
    input  logic [31:0] imm,
    input  logic [31:0] rs2_val,
    input  logic [4:0]  rd_in,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic        rsp_wb,
    output logic        rsp_err
);

    localparam int unsigned CNT_W     = 2;
    localparam int unsigned MEM_BYTES = MEM_WORDS * 4;
    // MEM_WORDS is a power of two, so the wrap is a mask
    localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);

    lsu_state_e        state_q, state_d;
    lsu_req_t          req_q, req_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic        req_ready_d, mem_en_d, rsp_valid_d, rsp_wb_d, rsp_err_d;
    logic [3:0]  mem_we_d;
    logic [31:0] mem_addr_d, mem_wdata_d, rsp_data_d;
    logic [4:0]  rsp_rd_d;

    logic        accept;
    mem_op_t     in_op;
    logic [31:0] in_addr_raw, in_addr;
    logic        in_trap;
    logic [31:0] load_c;

    assign accept      = req_valid & req_ready;
    assign in_op       = decode_op(Single_Instruction);
    assign in_addr_raw = rs1_val + imm;

`ifdef LSU_MISALIGN_TRAP_EN
    assign in_addr = in_addr_raw;
    assign in_trap = misaligned(in_op, in_addr_raw[1:0]);
`else
    assign in_addr = align_addr(in_op, in_addr_raw);
    assign in_trap = 1'b0;
`endif

    lsu_load_align u_align (
        .word        (mem_rdata),
        .offset      (req_q.offset),
        .size        (req_q.op.size),
        .is_unsigned (req_q.op.is_unsigned),
        .value_c     (load_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ((in_op.is_load || in_op.is_store) && !in_trap)
                                             ? ST_ACCESS : ST_RESP;
            ST_ACCESS: state_d = req_q.op.is_store ? ST_RESP : ST_WAIT;
            ST_WAIT:   if (cnt_q == '0) state_d = ST_RESP;
            ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, keyed on the transition being taken
    always_comb begin
        req_ready_d = (state_d == ST_IDLE);
        mem_en_d    = 1'b0;
        mem_we_d    = WE_NONE;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        rsp_valid_d = (state_d == ST_RESP);
        rsp_data_d  = rsp_data;
        rsp_rd_d    = rsp_rd;
        rsp_wb_d    = rsp_wb;
        rsp_err_d   = rsp_err;
        req_d       = req_q;
        cnt_d       = cnt_q;

        if (state_q == ST_IDLE && accept) begin
            req_d = '{op: in_op, offset: in_addr[1:0], rd: rd_in};
        end
        if (state_q == ST_IDLE && state_d == ST_ACCESS) begin
            mem_en_d   = 1'b1;
            mem_addr_d = {in_addr[31:2], 2'b00} & ADDR_MASK;
            if (in_op.is_store) begin
                mem_we_d = store_strobe(in_op.size, in_addr[1:0]);
                case (in_op.size)
                    SZ_B:    mem_wdata_d = {4{rs2_val[7:0]}};
                    SZ_H:    mem_wdata_d = {2{rs2_val[15:0]}};
                    default: mem_wdata_d = rs2_val;
                endcase
            end
        end
        if (state_q == ST_IDLE && state_d == ST_RESP) begin
            rsp_data_d = in_trap ? in_addr_raw : '0;
            rsp_rd_d   = rd_in;
            rsp_wb_d   = 1'b0;
            rsp_err_d  = in_trap;
        end
        if (state_q == ST_ACCESS) begin
            cnt_d = CNT_W'(RD_LAT - 1);
            if (state_d == ST_RESP) begin
                rsp_data_d = '0;
                rsp_rd_d   = req_q.rd;
                rsp_wb_d   = 1'b0;
                rsp_err_d  = 1'b0;
            end
        end
        if (state_q == ST_WAIT) begin
            if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            if (state_d == ST_RESP) begin
                rsp_data_d = load_c;
                rsp_rd_d   = req_q.rd;
                rsp_wb_d   = req_q.op.is_load && (req_q.rd != '0);
                rsp_err_d  = 1'b0;
            end
        end
        if (state_d == ST_IDLE) begin
            rsp_data_d = '0;
            rsp_rd_d   = '0;
            rsp_wb_d   = 1'b0;
            rsp_err_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_ready <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= WE_NONE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_rd    <= '0;
            rsp_wb    <= 1'b0;
            rsp_err   <= 1'b0;
            req_q     <= '0;
            cnt_q     <= '0;
        end else begin
            req_ready <= req_ready_d;
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            rsp_rd    <= rsp_rd_d;
            rsp_wb    <= rsp_wb_d;
            rsp_err   <= rsp_err_d;
            req_q     <= req_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule
